branch_resolve_unit: RTL

Consumer-side counterpart of the IF-stage branch predictor. It carries each IF prediction alongside its instruction into ID and resolves it against the real outcome (zero_flag, computed target). It issues a registered flush/redirect to the fetch path on mispredict, and a registered training update back to the prediction table for every resolved branch.

---
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Purpose : resolves IF branch predictions in ID, drives flush/redirect and predictor training.
// Latency : 1 cycle from the resolving ID cycle to flush/redirect/update outputs.
// Backpr. : stall holds the carried prediction and defers resolution; no ready/credit path.
//
// Ports   : clk/arst_n (async active-low); stall, if_pred_taken/if_pred_target from IF;
//           ID_PC, ID_INST, zero_flag, branch_target from ID; flush, redirect_valid,
//           redirect_pc to fetch; upd_valid/upd_pc/upd_taken/upd_target to the predictor;
//           branch_cnt/mispredict_cnt performance counters.
// Option  : define PERF_CNT_EN to build the saturating counters; otherwise they read 0.
module branch_resolve_unit #(
  parameter int         XLEN          = 32,
  parameter logic [6:0] BRANCH_OPCODE = 7'b1100011,
  parameter int         CNT_W         = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             stall,
  input  logic             if_pred_taken,
  input  logic [XLEN-1:0]  if_pred_target,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [31:0]      ID_INST,
  input  logic             zero_flag,
  input  logic [XLEN-1:0]  branch_target,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t          state, state_nxt;
  logic            id_pred_valid;
  logic            id_pred_taken;
  logic [XLEN-1:0] id_pred_target;

  logic            is_br;
  logic [2:0]      funct3;
  logic            actual_taken;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] fallthru_pc;

  // Only opcode and funct3 matter here; the rest of the word is decoded elsewhere.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{ID_INST[31:15], ID_INST[11:7]};

  // Prediction travels with its instruction from IF into ID. A flush kills the
  // carried prediction even while stalled, since both IF and ID are wrong-path.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      id_pred_valid  <= 1'b0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (flush) begin
      id_pred_valid  <= 1'b0;
    end else if (!stall) begin
      id_pred_valid  <= 1'b1;
      id_pred_taken  <= if_pred_taken;
      id_pred_target <= if_pred_target;
    end
  end

  always_comb begin
    is_br  = (ID_INST[6:0] == BRANCH_OPCODE);
    funct3 = ID_INST[14:12];
    case (funct3)
      3'b000:  actual_taken = zero_flag;   // BEQ
      3'b001:  actual_taken = !zero_flag;  // BNE
      default: actual_taken = 1'b0;
    endcase
    // The ID slot during RECOVER is wrong-path, so it never resolves.
    resolve     = is_br && id_pred_valid && !stall && (state == IDLE);
    // Target only matters when the branch was actually taken.
    mispredict  = resolve && ((actual_taken != id_pred_taken) ||
                              (actual_taken && (id_pred_target != branch_target)));
    fallthru_pc = ID_PC + XLEN'(4);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mispredict) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
    end else begin
      flush          <= mispredict;
      redirect_valid <= mispredict;
      upd_valid      <= resolve;
      if (mispredict) redirect_pc <= actual_taken ? branch_target : fallthru_pc;
      if (resolve) begin
        upd_pc     <= ID_PC;
        upd_taken  <= actual_taken;
        upd_target <= branch_target;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve && (branch_cnt != {CNT_W{1'b1}}))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && (mispredict_cnt != {CNT_W{1'b1}}))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule
